pulse_to_gate: RTL and testbench
================================

# pulse_to_gate

Converts single-cycle trigger pulses (one-shot key-press events) back into held gate levels of programmable length, for the synth voice path. A trigger starts a gate of `len` clock cycles. A trigger during an active gate forces a short low gap so downstream envelope logic sees a fresh rising edge. The block sits between the key-event logic and the envelope/oscillator enable inputs.

## Interface
- `CNT_W`, default 16: width of the gate-length input and internal counter.
- `GAP_CYCLES`, default 4: low cycles inserted on retrigger. Must be ≥1 and < 2^CNT_W.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `trig`  in  1  trigger pulse, sampled every posedge. Consecutive high cycles count as separate triggers.
- `len`  in  CNT_W  gate length in cycles, sampled only on the edge where `trig`=1.
- `gate`  out  1  held gate level (registered).
- `gate_start`  out  1  one-cycle pulse, high in the first cycle `gate`=1 of each gate.
- `gate_end`  out  1  one-cycle pulse, high in the first cycle `gate`=0 after a gate, except when the gate ends by reset.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, GATE, GAP. Internal registers: `cnt` (CNT_W), `pend_len` (CNT_W).
- **IDLE**:
  - `trig`=1, `len`≠0 → GATE, `cnt`=`len`.
  - `trig`=1, `len`=0 → ignored; stay IDLE.
- **GATE** (`gate`=1):
  - `cnt` decrements each cycle.
  - Gate lasts exactly `len` cycles, then → IDLE.
  - `trig`=1 (any `len`) → GAP, `pend_len`=`len`, `cnt`=GAP_CYCLES.
  - Retrigger takes priority over normal expiry, including on the final gate cycle.
- **GAP** (`gate`=0, `busy`=1):
  - Counts down GAP_CYCLES.
  - `trig` during GAP overwrites `pend_len` (latest wins) and does not restart the gap.
  - At gap end: `pend_len`≠0 → GATE with `cnt`=`pend_len`; `pend_len`=0 → IDLE with no gate.
- `gate_start` and `gate_end` are registered with `gate` and derived from its next-state transition.
- Counter arithmetic is unsigned CNT_W. `len`=2^CNT_W−1 is the maximum length; `cnt` never wraps.
- Reset (any state, any cycle):
  - `gate`=0, `gate_start`=0, `gate_end`=0, `busy`=0.
  - State=IDLE, `cnt`=0, `pend_len`=0.
  - A `trig` on the reset edge is discarded.

## Timing
- Trigger latency: `trig` sampled at edge E0 → `gate`=1 and `gate_start`=1 after E0.
- `gate` stays high through the cycle ending at edge E0+`len`, and is low after that edge.
- `gate_end`=1 for the one cycle following edge E0+`len`.
- Retrigger at edge Er:
  - `gate`=0 and `gate_end`=1 after Er.
  - `gate` stays low for exactly GAP_CYCLES cycles.
  - `gate`=1 and `gate_start`=1 after edge Er+GAP_CYCLES.
- `busy` rises with `gate` on a trigger from IDLE. It falls in the same cycle `gate` falls on expiry, or when a gap ends with `pend_len`=0.
- Back-to-back: a trigger sampled on the edge where GATE expires into IDLE is a retrigger (→ GAP), not a new gate from IDLE.
- Reset mid-gate: `gate` low after the reset edge, with no `gate_end` pulse.

## Test plan
- **Reset values**: hold reset 2 cycles with `trig`=1 → all outputs 0 and `busy`=0 throughout; no gate after reset releases with `trig`=0.
- **Basic gate**: `trig` for 1 cycle, `len`=5 →
  - `gate` high exactly 5 cycles, starting the cycle after the trigger edge;
  - `gate_start` on cycle 1 and `gate_end` on cycle 6;
  - `busy` equals `gate`.
- **Zero length**: `trig` with `len`=0 in IDLE → `gate`, `busy` and the pulses all stay 0.
- **Retrigger** (GAP_CYCLES=4): `len`=10, then a second `trig` with `len`=3 on gate cycle 6 →
  - `gate` low 4 cycles, with `gate_end` on the first low cycle;
  - then high 3 cycles, with a new `gate_start`;
  - then low, with `gate_end`; `busy` stays high from the first gate until that final fall.
- **Triggers during gap**: during the gap, `trig` with `len`=7 then `len`=0 → gap not extended; after the gap, `gate` stays low and `busy` falls.
- **Reset mid-gate and edge cases**:
  - Reset on gate cycle 3 of `len`=8 → `gate` low after the reset edge, no `gate_end`.
  - `len`=1 → exactly one high cycle, with `gate_start` and `gate_end` on adjacent cycles.

Source files
------------

// File: rtl/pulse_to_gate.sv
// -----------------------------------------------------------------------------
// pulse_to_gate
//
// Turns one-cycle trigger pulses (key-press events) into held gate levels of a
// programmable length, feeding the envelope/oscillator enables of a synth
// voice. If a trigger arrives while a gate is already high, the gate is forced
// low for a short gap. Downstream envelope logic therefore always sees a fresh
// rising edge for the new note.
//
// Parameters
//   CNT_W       width of the gate-length input and of the internal counters
//   GAP_CYCLES  low cycles inserted on a retrigger (1 .. 2^CNT_W-1)
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   trig        trigger pulse; each high cycle counts as a separate trigger
//   len         gate length in cycles, sampled only on edges where trig=1
//   gate        held gate level (registered)
//   gate_start  one-cycle pulse in the first high cycle of every gate
//   gate_end    one-cycle pulse in the first low cycle after a gate
//               (not produced when the gate is cut short by reset)
//   busy        high whenever the block is not idle (gate or gap in progress)
//
// Timing summary
//   A trigger sampled at edge E0 raises gate right after E0. The gate stays
//   high through the cycle that ends at edge E0+len.
//   A retrigger sampled at edge Er drops the gate right after Er. The gate
//   stays low for GAP_CYCLES cycles and rises again after Er+GAP_CYCLES,
//   using the most recent length seen during the gap. A zero length at gap
//   end returns the block to idle without raising the gate.
// -----------------------------------------------------------------------------
module pulse_to_gate #(
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [CNT_W-1:0] len,
  output logic             gate,
  output logic             gate_start,
  output logic             gate_end,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GATE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

  // State and datapath registers.
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;       // cycles remaining in the current gate/gap
  logic [CNT_W-1:0] r_pend_len;  // length to launch when the gap finishes

  // Registered outputs.
  logic r_gate;
  logic r_gate_start;
  logic r_gate_end;
  logic r_busy;

  // Next-state values.
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_pend_nxt;
  logic [CNT_W-1:0] w_pend_eff;  // pend_len as updated by a trigger on this edge
  logic             w_last;      // current gate/gap cycle is its final one

  // Next output values, decoded from the state transition.
  logic w_gate_nxt;
  logic w_gate_start_nxt;
  logic w_gate_end_nxt;
  logic w_busy_nxt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pend_len   <= '0;
      r_gate       <= 1'b0;
      r_gate_start <= 1'b0;
      r_gate_end   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pend_len   <= w_pend_nxt;
      r_gate       <= w_gate_nxt;
      r_gate_start <= w_gate_start_nxt;
      r_gate_end   <= w_gate_end_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // The counter is loaded with the number of cycles to spend in GATE or GAP.
  // A count of 1 marks the final cycle. It is never decremented past 1, so a
  // length of 2^CNT_W-1 cannot wrap. The "<= 1" compare also makes a stray
  // zero count exit instead of hanging.
  assign w_last = (r_cnt <= CNT_W'(1));

  // A trigger on the gap's final edge still counts as "latest wins".
  assign w_pend_eff = trig ? len : r_pend_len;

  // NOTE: every signal written here receives a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend_len;

    unique case (r_state)
      S_IDLE: begin
        // A zero-length trigger from idle is ignored outright.
        if (trig && (len != '0)) begin
          w_state_nxt = S_GATE;
          w_cnt_nxt   = len;
        end
      end

      S_GATE: begin
        // A retrigger wins over expiry, even on the final gate cycle.
        // A zero length is still accepted here: the gap is inserted
        // and the block then falls back to idle.
        if (trig) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = GAP_LOAD;
          w_pend_nxt  = len;
        end else if (w_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end

      S_GAP: begin
        // Triggers only update the pending length; the gap is not restarted.
        w_pend_nxt = w_pend_eff;
        if (w_last) begin
          w_pend_nxt = '0;
          if (w_pend_eff != '0) begin
            w_state_nxt = S_GATE;
            w_cnt_nxt   = w_pend_eff;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_pend_nxt  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // Outputs are computed from the next state and registered alongside it, so
  // the pulses line up exactly with the edges of the registered gate. Reset
  // clears everything directly, which is why a reset never produces gate_end.
  always_comb begin
    w_gate_nxt       = (w_state_nxt == S_GATE);
    w_gate_start_nxt = w_gate_nxt && !r_gate;
    w_gate_end_nxt   = r_gate && !w_gate_nxt;
    w_busy_nxt       = (w_state_nxt != S_IDLE);
  end

  assign gate       = r_gate;
  assign gate_start = r_gate_start;
  assign gate_end   = r_gate_end;
  assign busy       = r_busy;

endmodule

// File: tb/tb_pulse_to_gate.sv
// -----------------------------------------------------------------------------
// tb_pulse_to_gate
//
// Directed bench for pulse_to_gate (CNT_W=16, GAP_CYCLES=4). A table of
// {reset, trig, len, expected outputs} rows is applied one clock edge per
// row. The outputs are compared 1 time unit after each rising edge.
// A few hand-written sequences cover long gates and trig on a reset edge.
// -----------------------------------------------------------------------------
module tb_pulse_to_gate;

  localparam int CNT_W = 16;
  localparam int GAP   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             trig;
  logic [CNT_W-1:0] len;
  logic             gate;
  logic             gate_start;
  logic             gate_end;
  logic             busy;

  pulse_to_gate #(.CNT_W(CNT_W), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .trig       (trig),
    .len        (len),
    .gate       (gate),
    .gate_start (gate_start),
    .gate_end   (gate_end),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // exp = {gate, gate_start, gate_end, busy} after the edge on which the
  // row's inputs are sampled.
  typedef struct {
    logic             rst;
    logic             trig;
    logic [CNT_W-1:0] len;
    logic [3:0]       exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic rst, input logic trg, input logic [CNT_W-1:0] l,
                     input logic [3:0] e);
    vec_t v;
    v.rst  = rst;
    v.trig = trg;
    v.len  = l;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {gate,start,end,busy}=%b expected %b", name, act, exp);
  endtask

  // Drive inputs, then let one rising edge sample them.
  task automatic step(input logic rst, input logic trg, input logic [CNT_W-1:0] l);
    reset = rst;
    trig  = trg;
    len   = l;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {gate, gate_start, gate_end, busy};
  endfunction

  initial begin
    // Reset held two cycles with trig high: everything stays low.
    add(1, 1, 5, 4'b0000);
    add(1, 1, 5, 4'b0000);
    add(0, 0, 0, 4'b0000);
    add(0, 0, 0, 4'b0000);
    // Basic gate, len=5.
    add(0, 1, 5, 4'b1101);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 4'b1001);
    add(0, 0, 0, 4'b0010);
    add(0, 0, 0, 4'b0000);
    // Zero length from idle is ignored.
    add(0, 1, 0, 4'b0000);
    add(0, 0, 0, 4'b0000);
    // Retrigger: len=10, second trig (len=3) sampled at end of gate cycle 6.
    add(0, 1, 10, 4'b1101);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 4'b1001);
    add(0, 1, 3, 4'b0011);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 4'b0001);
    add(0, 0, 0, 4'b1101);
    add(0, 0, 0, 4'b1001);
    add(0, 0, 0, 4'b1001);
    add(0, 0, 0, 4'b0010);
    add(0, 0, 0, 4'b0000);
    // Triggers during gap (len=7 then len=0): gap not extended, ends idle.
    add(0, 1, 4, 4'b1101);
    add(0, 1, 9, 4'b0011);
    add(0, 1, 7, 4'b0001);
    add(0, 1, 0, 4'b0001);
    add(0, 0, 0, 4'b0001);
    add(0, 0, 0, 4'b0000);
    add(0, 0, 0, 4'b0000);
    // len=1: start and end on adjacent cycles.
    add(0, 1, 1, 4'b1101);
    add(0, 0, 0, 4'b0010);
    add(0, 0, 0, 4'b0000);
    // Trigger on the expiry edge is a retrigger (gap), not a new gate.
    add(0, 1, 2, 4'b1101);
    add(0, 0, 0, 4'b1001);
    add(0, 1, 1, 4'b0011);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 4'b0001);
    add(0, 0, 0, 4'b1101);
    add(0, 0, 0, 4'b0010);
    add(0, 0, 0, 4'b0000);
    // Trigger on the gap's final edge supplies the pending length.
    add(0, 1, 3, 4'b1101);
    add(0, 1, 0, 4'b0011);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 4'b0001);
    add(0, 1, 2, 4'b1101);
    add(0, 0, 0, 4'b1001);
    add(0, 0, 0, 4'b0010);
    add(0, 0, 0, 4'b0000);
    // Reset on gate cycle 3 of len=8: gate drops, no gate_end.
    add(0, 1, 8, 4'b1101);
    add(0, 0, 0, 4'b1001);
    add(0, 0, 0, 4'b1001);
    add(1, 0, 0, 4'b0000);
    add(0, 0, 0, 4'b0000);
    add(0, 0, 0, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].trig, vecs[i].len);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Maximum length: gate holds for a long run; the counter must not wrap.
    step(0, 1, 16'hFFFF);
    check("max_start", outs(), 4'b1101);
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0);
      check($sformatf("max_hold%0d", i), outs(), 4'b1001);
    end
    // Retrigger with len=0: gap of GAP cycles, then idle with no gate.
    step(0, 1, 0);
    check("max_retrig_end", outs(), 4'b0011);
    for (int i = 1; i < GAP; i++) begin
      step(0, 0, 0);
      check($sformatf("max_gap%0d", i), outs(), 4'b0001);
    end
    step(0, 0, 0);
    check("max_gap_idle", outs(), 4'b0000);

    // A trig on the reset edge mid-gate is discarded, with no gate_end.
    step(0, 1, 5);
    check("rst_trig_start", outs(), 4'b1101);
    step(1, 1, 5);
    check("rst_trig_edge", outs(), 4'b0000);
    step(0, 0, 0);
    check("rst_trig_after", outs(), 4'b0000);
    step(0, 0, 0);
    check("rst_trig_after2", outs(), 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
